// File: rtl/gru_pkg.sv
// Shared constants, types and the element-slice helper for the GRU state unloader.
// Element k of a chunk lives at bits [k*W +: W].
package gru_pkg;

  localparam int EP         = 48;
  localparam int WI_vec     = 4;
  localparam int WF_vec     = 12;
  localparam int gru_size   = 624;
  localparam int time_steps = 2;
  localparam int DEPTH      = 4;

  localparam int W   = WI_vec + WF_vec;
  localparam int CPS = gru_size / EP;
  localparam int CW  = EP * W;

  // A counter that only ever holds 0 still needs one bit.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ELEM_W     = ctr_w(EP);
  localparam int CHUNK_W    = ctr_w(CPS);
  localparam int STEP_W     = ctr_w(time_steps);
  localparam int FIFO_CNT_W = $clog2(DEPTH) + 1;

  localparam logic [ELEM_W-1:0]  ELEM_LAST  = ELEM_W'(EP - 1);
  localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(CPS - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(time_steps - 1);

  typedef logic [CW-1:0] chunk_t;
  typedef logic [W-1:0]  elem_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic elem_t elem(input chunk_t c, input logic [ELEM_W-1:0] k);
    return c[k*W +: W];
  endfunction

endpackage

// File: rtl/gru_chunk_fifo.sv
// Synchronous chunk FIFO with combinational head read; a write while full is ignored.
// Pop and push in the same cycle are both honoured; full/empty/count reflect the registered occupancy.
module gru_chunk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign do_wr = wr_vld && !full;
  assign do_rd = rd_en && !empty;
  assign rd_dat = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + (AW+1)'(1);
    if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/gru_state_unloader.sv
// Buffers EP-wide hidden-state chunks and streams one element per beat; first beat two edges after chunk_valid, then 1/cycle.
// out_ready stalls the stream; the cell cannot be stalled, so a full FIFO drops the chunk and sets sticky overflow. GRU_UNLOAD_CKSUM_EN adds a per-step checksum.
module gru_state_unloader
  import gru_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          chunk_valid,
  input  logic [CW-1:0] chunk_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last_step,
  output logic          out_last,
  output logic          overflow,
  output logic          busy
`ifdef GRU_UNLOAD_CKSUM_EN
  ,
  output logic [W-1:0]  cksum,
  output logic          cksum_valid
`endif
);

  state_t               state_q, state_d;
  chunk_t               shreg_q, shreg_d;
  logic [ELEM_W-1:0]    elem_ctr_q, elem_ctr_d;
  logic [CHUNK_W-1:0]   chunk_ctr_q, chunk_ctr_d;
  logic [STEP_W-1:0]    step_ctr_q, step_ctr_d;
  logic                 out_valid_q, out_valid_d;
  elem_t                out_data_q, out_data_d;
  logic                 out_last_step_q, out_last_step_d;
  logic                 out_last_q, out_last_d;
  logic                 overflow_q, overflow_d;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_CNT_W-1:0] fifo_count;
  chunk_t               fifo_rd_dat;
  logic                 hs;

  gru_chunk_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (chunk_valid),
    .wr_dat (chunk_data),
    .rd_en  (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign hs = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    elem_ctr_d  = elem_ctr_q;
    chunk_ctr_d = chunk_ctr_q;
    step_ctr_d  = step_ctr_q;
    fifo_pop    = 1'b0;
    overflow_d  = overflow_q || (chunk_valid && fifo_full);

    if (state_q == ST_EMPTY) begin
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        shreg_d    = fifo_rd_dat;
        elem_ctr_d = '0;
        state_d    = ST_SHIFT;
      end
    end else if (hs) begin
      if (elem_ctr_q != ELEM_LAST) begin
        elem_ctr_d = elem_ctr_q + ELEM_W'(1);
      end else begin
        elem_ctr_d = '0;
        if (chunk_ctr_q == CHUNK_LAST) begin
          chunk_ctr_d = '0;
          step_ctr_d  = (step_ctr_q == STEP_LAST) ? '0 : step_ctr_q + STEP_W'(1);
        end else begin
          chunk_ctr_d = chunk_ctr_q + CHUNK_W'(1);
        end
        // Reload straight from the FIFO head so back-to-back chunks have no bubble.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rd_dat;
        end else begin
          state_d = ST_EMPTY;
        end
      end
    end

    out_valid_d     = (state_d == ST_SHIFT);
    out_data_d      = out_valid_d ? elem(shreg_d, elem_ctr_d) : '0;
    out_last_step_d = out_valid_d && (elem_ctr_d == ELEM_LAST) && (chunk_ctr_d == CHUNK_LAST);
    out_last_d      = out_last_step_d && (step_ctr_d == STEP_LAST);
  end

`ifdef GRU_UNLOAD_CKSUM_EN
  elem_t acc_q, acc_d;
  elem_t cksum_q, cksum_d;
  logic  cksum_valid_q, cksum_valid_d;

  always_comb begin
    acc_d         = acc_q;
    cksum_d       = cksum_q;
    cksum_valid_d = 1'b0;
    if (hs) begin
      if (out_last_step_q) begin
        cksum_d       = acc_q + out_data_q;
        cksum_valid_d = 1'b1;
        acc_d         = '0;
      end else begin
        acc_d = acc_q + out_data_q;
      end
    end
  end

  assign cksum       = cksum_q;
  assign cksum_valid = cksum_valid_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_EMPTY;
      shreg_q         <= '0;
      elem_ctr_q      <= '0;
      chunk_ctr_q     <= '0;
      step_ctr_q      <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_step_q <= 1'b0;
      out_last_q      <= 1'b0;
      overflow_q      <= 1'b0;
`ifdef GRU_UNLOAD_CKSUM_EN
      acc_q           <= '0;
      cksum_q         <= '0;
      cksum_valid_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      elem_ctr_q      <= elem_ctr_d;
      chunk_ctr_q     <= chunk_ctr_d;
      step_ctr_q      <= step_ctr_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_step_q <= out_last_step_d;
      out_last_q      <= out_last_d;
      overflow_q      <= overflow_d;
`ifdef GRU_UNLOAD_CKSUM_EN
      acc_q           <= acc_d;
      cksum_q         <= cksum_d;
      cksum_valid_q   <= cksum_valid_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last_step = out_last_step_q;
  assign out_last      = out_last_q;
  assign overflow      = overflow_q;
  assign busy          = (fifo_count != '0) || (state_q == ST_SHIFT);

endmodule
